// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Fixed AES-128 round keys (all-zero cipher key), FSM encodings,
//               inverse S-box and helpers shared by the AES cores.
// Revision    : 1.0
// ============================================================================
package aes_pkg;

  typedef logic [15:0][7:0] aes_state_t;

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_ISR  = 3'd1;
  localparam logic [2:0] c_ISB  = 3'd2;
  localparam logic [2:0] c_ARK  = 3'd3;
  localparam logic [2:0] c_IMC  = 3'd4;
  localparam logic [2:0] c_DONE = 3'd5;

  localparam logic [127:0] c_RK0  = 128'h00000000000000000000000000000000;
  localparam logic [127:0] c_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] c_RK2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] c_RK3  = 128'h90973450696ccffaf2f457330b0fac99;
  localparam logic [127:0] c_RK4  = 128'hee06da7b876a1581759e42b27e91ee2b;
  localparam logic [127:0] c_RK5  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
  localparam logic [127:0] c_RK6  = 128'hec614b851425758c99ff09376ab49ba7;
  localparam logic [127:0] c_RK7  = 128'h217517873550620bacaf6b3cc61bf09b;
  localparam logic [127:0] c_RK8  = 128'h0ef903333ba9613897060a04511dfa9f;
  localparam logic [127:0] c_RK9  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
  localparam logic [127:0] c_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  localparam logic [7:0] c_INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return c_INV_SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] round_key(input logic [3:0] r);
    case (r)
      4'd0:    return c_RK0;
      4'd1:    return c_RK1;
      4'd2:    return c_RK2;
      4'd3:    return c_RK3;
      4'd4:    return c_RK4;
      4'd5:    return c_RK5;
      4'd6:    return c_RK6;
      4'd7:    return c_RK7;
      4'd8:    return c_RK8;
      4'd9:    return c_RK9;
      4'd10:   return c_RK10;
      default: return '0;
    endcase
  endfunction

  // Byte k (k = 4*column + row) sits at packed index 15-k, so byte 0 is the MSB.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4'(15 - (4 * c + r))] = s[4'(15 - (4 * ((c - r + 4) % 4) + r))];
      end
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_serial_decrypt_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_serial_decrypt_if
// Description : Ciphertext-in / plaintext-out handshake bundle.
// Revision    : 1.0
// ============================================================================
interface aes_serial_decrypt_if;
  logic         i_valid;
  logic [127:0] i_dat;
  logic         i_read;
  logic         o_input_consumed;
  logic         o_valid;
  logic [127:0] o_dat;

  modport slave  (input  i_valid, i_dat, i_read,
                  output o_input_consumed, o_valid, o_dat);
  modport master (output i_valid, i_dat, i_read,
                  input  o_input_consumed, o_valid, o_dat);
endinterface
`default_nettype wire

// File: rtl/aes_inv_mix_column_quarter.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_mix_column_quarter
// Description : Row-0 InvMixColumns output byte of a 32-bit column (MSB = row 0).
// Revision    : 1.0
// ============================================================================
module aes_inv_mix_column_quarter
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [7:0]  o_byte
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  assign o_byte = gmul(i_col[31:24], 4'he) ^ gmul(i_col[23:16], 4'hb) ^
                  gmul(i_col[15:8],  4'hd) ^ gmul(i_col[7:0],   4'h9);

endmodule
`default_nettype wire

// File: rtl/aes_serial_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : aes_serial_decrypt
// Description : Byte-serial AES-128 inverse cipher with fixed all-zero-key schedule.
// Revision    : 1.0
// ============================================================================
module aes_serial_decrypt
  import aes_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  aes_serial_decrypt_if.slave  bus
);

  logic [2:0]  r_fsm;
  logic [3:0]  r_round;
  logic [3:0]  r_byte;
  aes_state_t  r_st;
  logic [23:0] r_buf;
  logic        r_consumed;
  logic        r_valid;

  logic [1:0]  w_col;
  logic [1:0]  w_row;
  logic [31:0] w_orig;
  logic [31:0] w_rot;
  logic [7:0]  w_imc;

  assign w_col = r_byte[3:2];
  assign w_row = r_byte[1:0];

  // Bytes 0..2 of a column are overwritten before its last output byte is
  // formed, so their pre-round values come from r_buf after the first byte.
  assign w_orig = {(w_row == 2'd0) ? r_st[~{w_col, 2'd0}] : r_buf[23:16],
                   (w_row == 2'd0) ? r_st[~{w_col, 2'd1}] : r_buf[15:8],
                   (w_row == 2'd0) ? r_st[~{w_col, 2'd2}] : r_buf[7:0],
                   r_st[~{w_col, 2'd3}]};

  always_comb begin
    case (w_row)
      2'd0:    w_rot = w_orig;
      2'd1:    w_rot = {w_orig[23:0], w_orig[31:24]};
      2'd2:    w_rot = {w_orig[15:0], w_orig[31:16]};
      default: w_rot = {w_orig[7:0],  w_orig[31:8]};
    endcase
  end

  aes_inv_mix_column_quarter u_imc (
    .i_col  (w_rot),
    .o_byte (w_imc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fsm      <= c_IDLE;
      r_round    <= 4'd0;
      r_byte     <= 4'd0;
      r_st       <= '0;
      r_buf      <= '0;
      r_consumed <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_consumed <= 1'b0;
      case (r_fsm)
        c_IDLE: begin
          if (bus.i_valid) begin
            r_st       <= bus.i_dat ^ c_RK10;
            r_round    <= 4'd9;
            r_consumed <= 1'b1;
            r_fsm      <= c_ISR;
          end
        end
        c_ISR: begin
          r_st  <= inv_shift_rows(r_st);
          r_fsm <= c_ISB;
        end
        c_ISB: begin
          r_st[~r_byte] <= inv_sbox(r_st[~r_byte]);
          r_byte        <= r_byte + 4'd1;
          if (r_byte == 4'd15) r_fsm <= c_ARK;
        end
        c_ARK: begin
          r_st <= r_st ^ round_key(r_round);
          if (r_round != 4'd0) begin
            r_fsm <= c_IMC;
          end else begin
            r_fsm   <= c_DONE;
            r_valid <= 1'b1;
          end
        end
        c_IMC: begin
          r_st[~r_byte] <= w_imc;
          if (w_row == 2'd0) r_buf <= w_orig[31:8];
          r_byte <= r_byte + 4'd1;
          if (r_byte == 4'd15) begin
            r_round <= r_round - 4'd1;
            r_fsm   <= c_ISR;
          end
        end
        c_DONE: begin
          if (bus.i_read) begin
            r_valid <= 1'b0;
            r_fsm   <= c_IDLE;
          end
        end
        default: r_fsm <= c_IDLE;
      endcase
    end
  end

  assign bus.o_input_consumed = r_consumed;
  assign bus.o_valid          = r_valid;
  assign bus.o_dat            = r_st;

endmodule
`default_nettype wire

// File: tb/tb_aes_serial_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_serial_decrypt
// Description : Scoreboard bench for aes_serial_decrypt using zero-key AES vectors.
// Revision    : 1.0
// ============================================================================
module tb_aes_serial_decrypt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_serial_decrypt_if bus ();

  aes_serial_decrypt dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Known zero-key AES-128 pairs: ciphertext -> plaintext.
  logic [127:0] ct_tab [6] = '{
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
    128'h3ad78e726c1ec02b7ebfe92b23d9ec34,
    128'h0336763e966d92595a567cc9ce537f5e,
    128'ha9a1631bf4996954ebc093957b234589,
    128'hff4f8391a6a40ca5b25d23bedd44a597,
    128'hdc43be40be0e53712f7e2bf5ca707209
  };
  logic [127:0] pt_tab [6] = '{
    128'h00000000000000000000000000000000,
    128'h80000000000000000000000000000000,
    128'hf34481ec3cc627bacd5dc3fb08f273e6,
    128'h9798c4640bad75c7c3227db910174e72,
    128'h96ab5c2ff612d9dfaae8c31f30c42168,
    128'h6a118a874519e64e9963798a503f1d35
  };

  logic [127:0] exp_q [$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  drv_timeouts = 0;
  int  to_seen = 0;
  bit  stream_mode = 1'b0;
  bit  done = 1'b0;

  int           cyc = 0;
  logic         rst_q = 1'b1;
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic         xfer_q = 1'b0;
  logic [127:0] pd = '0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_q  <= rst;
    pv     <= bus.o_valid;
    pr     <= bus.i_read;
    pd     <= bus.o_dat;
    xfer_q <= bus.o_valid & bus.i_read;
  end

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard
  int acc_cyc = 0;
  int prev_acc = 0;
  bit have_prev = 1'b0;
  logic [127:0] exp_v;

  always @(negedge clk) begin
    if (done) begin
      check_int("queue_empty_at_end", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
    if (drv_timeouts != to_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL driver_timeout: expired waits %0d required %0d", drv_timeouts, to_seen);
      to_seen = drv_timeouts;
    end
    if (rst_q) begin
      check_int("reset_o_valid", int'(bus.o_valid), 0);
      check_int("reset_o_input_consumed", int'(bus.o_input_consumed), 0);
      check_vec("reset_o_dat", bus.o_dat, '0);
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (bus.o_input_consumed) begin
        check_int("consumed_while_valid", int'(bus.o_valid), 0);
        if (stream_mode && have_prev) check_int("consume_period", cyc - prev_acc + 1, 327);
        have_prev = stream_mode;
        prev_acc  = cyc;
        acc_cyc   = cyc;
      end
      // Consumed-pulse cycle counts as cycle 1 of the block.
      if (bus.o_valid && !pv) check_int("latency", cyc - acc_cyc + 1, 325);
      if (pv && !pr) begin
        check_int("hold_o_valid", int'(bus.o_valid), 1);
        check_vec("hold_o_dat", bus.o_dat, pd);
      end
      if (xfer_q) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h required no output", pd);
        end else begin
          exp_v = exp_q.pop_front();
          check_vec("plaintext", pd, exp_v);
        end
      end
    end
  end

  // Driver
  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    int n;
    bus.i_valid = 1'b1;
    bus.i_dat   = ct;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_input_consumed && n < 2000);
    if (bus.o_input_consumed) exp_q.push_back(pt);
    else drv_timeouts++;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) drv_timeouts++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.i_valid = 1'b0;
    bus.i_dat   = '0;
    bus.i_read  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      send(ct_tab[k], pt_tab[k]);
      drain();
    end

    // Backpressure with a second block pending on i_valid.
    bus.i_read = 1'b0;
    send(ct_tab[3], pt_tab[3]);
    n = 0;
    while (!bus.o_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_valid) drv_timeouts++;
    bus.i_valid = 1'b1;
    bus.i_dat   = ct_tab[4];
    repeat (50) @(negedge clk);
    bus.i_read = 1'b1;
    send(ct_tab[4], pt_tab[4]);
    drain();

    // Abort a block with reset, then verify a clean block.
    send(ct_tab[5], pt_tab[5]);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    send(ct_tab[5], pt_tab[5]);
    drain();

    // i_valid and i_read held high: back-to-back blocks.
    stream_mode = 1'b1;
    bus.i_valid = 1'b1;
    for (int k = 1; k < 4; k++) begin
      bus.i_dat = ct_tab[k];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.o_input_consumed && n < 2000);
      if (bus.o_input_consumed) exp_q.push_back(pt_tab[k]);
      else drv_timeouts++;
      if (k == 3) bus.i_valid = 1'b0;
    end
    drain();
    stream_mode = 1'b0;

    done = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL monitor_did_not_finish: got running required finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/aes_serial_decrypt.md
AES_SERIAL_DECRYPT -- requirements
Module: aes_serial_decrypt

Interface
REQ-001 SHALL have no parameters; key schedule fixed (AES-128, all-zero key, same round keys rk0..rk10 as the team's encryption core aespp).
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  ciphertext on i_dat is offered.
REQ-005 SHALL have port i_dat  input  128  ciphertext block, byte ordering identical to aespp o_dat.
REQ-006 SHALL have port i_read  input  1  consumer takes o_dat.
REQ-007 SHALL have port o_input_consumed  output  1  one-cycle pulse, i_dat captured.
REQ-008 SHALL have port o_valid  output  1  plaintext on o_dat valid.
REQ-009 SHALL have port o_dat  output  128  plaintext, aespp byte ordering; don't-care while o_valid=0.

Function
REQ-010 SHALL implement the standard inverse cipher: ARK(rk10); rounds 9..1 = InvShiftRows, InvSubBytes, ARK(rk_r), InvMixColumns; final = InvShiftRows, InvSubBytes, ARK(rk0).
REQ-011 SHALL use FSM states IDLE, ISR, ISB, ARK, IMC, DONE plus a 4-bit round counter (9 down to 0) and a 4-bit byte counter.
REQ-012 IDLE: when i_valid=1, state <= i_dat ^ rk10, round <= 9, o_input_consumed=1 for the next cycle only, go ISR.
REQ-013 ISR: whole-state inverse row permutation in 1 cycle, go ISB.
REQ-014 ISB: one byte per cycle through a combinational inverse S-box, 16 cycles, byte counter wraps 15->0, go ARK.
REQ-015 ARK: state ^= rk_round in 1 cycle; go IMC if round!=0, else go DONE with o_valid <= 1.
REQ-016 IMC: one output byte per cycle, 16 cycles; each byte computed from its column's original four bytes (coefficients 0E,0B,0D,09) via a 3-byte column buffer; round decrements at exit; go ISR.
REQ-017 Latency SHALL be fixed: o_valid rises 325 cycles after the acceptance edge (1 + 9x34 + 18).
REQ-018 DONE: o_valid and o_dat held stable while i_read=0; i_read=1 at an edge -> o_valid <= 0, go IDLE.
REQ-019 i_valid SHALL be ignored in every state other than IDLE, including the DONE cycle where i_read=1; earliest new acceptance is the edge after leaving DONE.
REQ-020 o_input_consumed SHALL never be asserted while o_valid=1.

Reset
REQ-021 i_reset=1 at any edge SHALL force IDLE, round=0, byte counter=0, state=0, o_valid=0, o_input_consumed=0 (o_dat=0), aborting any block in progress.
REQ-022 Reset SHALL have priority over i_valid and i_read in the same cycle.

Structure
REQ-023 Package aes_pkg SHALL hold round-key constants rk0..rk10, FSM state encodings and the inverse S-box table, shared with aespp.
REQ-024 Sub-module aes_inv_mix_column_quarter SHALL compute one InvMixColumns output byte from a 32-bit column input, purely combinational.

Verification
REQ-025 Reset, i_valid with i_dat=66E94BD4EF8A2C3B884CFA59CA342B2E -> o_valid exactly 325 cycles after acceptance, o_dat=0.
REQ-026 Round trip: 1000 random plaintexts through aespp (i_blocks=0) then this block -> o_dat equals plaintext every time.
REQ-027 Backpressure: i_read=0 for 50 cycles after o_valid -> o_valid and o_dat stable, second pending i_valid not consumed (o_input_consumed=0).
REQ-028 i_reset pulsed at cycle 100 of a block -> o_valid=0 next cycle, no stale output; next block correct with latency 325.
REQ-029 i_valid and i_read tied high -> o_input_consumed pulses exactly 327 cycles apart, every output correct.
